spi_master_byte: RTL and testbench
==================================

SPI_MASTER_BYTE -- requirements
Module: spi_master_byte

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 4: SCLK half-period in sysClk cycles; legal range 2..255.
REQ-002 SHALL provide parameter SS_SETUP, default 2: sysClk cycles from SS falling to the first SCLK rising edge; also the SS hold time after the last SCLK falling edge; legal range 1..255.
REQ-003 SHALL provide parameter SS_IDLE, default 4: minimum sysClk cycles SS stays high between frames; legal range 1..255.
REQ-004 SHALL have port sysClk, input, 1: single system clock; all logic is on its rising edge.
REQ-005 SHALL have port usrReset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port tx, input, 8: byte to transmit, MSB first.
REQ-007 SHALL have port txValid, input, 1: tx is valid.
REQ-008 SHALL have port txLast, input, 1: qualified by txValid; 1 = release SS after this byte.
REQ-009 SHALL have port txReady, output, 1: block accepts a byte this cycle.
REQ-010 SHALL have port rx, output, 8: byte captured from MISO.
REQ-011 SHALL have port rxValid, output, 1: one-cycle pulse; rx is valid.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have ports SCLK, MOSI and SS (outputs, 1 bit each) and MISO (input, 1 bit).

Function
REQ-014 SHALL implement SPI mode 0: SCLK idles low; MOSI changes only on SCLK falling edges (or before the first rising edge); MISO is sampled on SCLK rising edges.
REQ-015 SHALL pass MISO through a 2-flop synchronizer; the sample point is the rising-edge cycle, using the synchronized value.
REQ-016 SHALL implement states IDLE, SETUP, XFER, WAIT, HOLD and GAP.
REQ-017 IDLE: txReady=1, SS=1; on txValid&&txReady, SHALL latch tx and txLast, drive SS=0 and MOSI=tx[7], and go to SETUP.
REQ-018 SETUP: SHALL count SS_SETUP cycles, then enter XFER.
REQ-019 XFER: SHALL toggle SCLK every CLK_DIV cycles for 16 half-periods (8 rising edges); byte time is 16*CLK_DIV cycles.
REQ-020 XFER: on each falling edge except the 8th, SHALL shift the next tx bit onto MOSI.
REQ-021 XFER: on each rising edge, SHALL shift the synchronized MISO into rx, LSB-in.
REQ-022 At the end of the 16th half-period, SHALL pulse rxValid for exactly one cycle with the complete rx.
REQ-023 In that same cycle, SHALL go to HOLD if the latched txLast=1, else to WAIT.
REQ-024 WAIT: SS=0, SCLK=0, txReady=1; on txValid, SHALL latch tx/txLast, set MOSI=tx[7] and re-enter XFER directly without SETUP delay.
REQ-025 WAIT SHALL have no timeout; SS stays low indefinitely.
REQ-026 HOLD: SHALL count SS_SETUP cycles, then drive SS=1 and go to GAP.
REQ-027 GAP: txReady=0; SHALL count SS_IDLE cycles, then go to IDLE.
REQ-028 txReady SHALL be 0 in SETUP, XFER, HOLD and GAP; the tx input is ignored there.
REQ-029 rx SHALL hold its value until the next rxValid.
REQ-030 Counters SHALL be 8 bits; the half-period counter reloads at CLK_DIV-1 and never wraps past 0.
REQ-031 A back-to-back burst SHALL keep SS low continuously; for CLK_DIV=4 the minimum gap between bytes is 1 sysClk cycle of SCLK low (the WAIT acceptance cycle) plus the normal low half-period.

Reset
REQ-032 On usrReset_n=0, SHALL immediately force state=IDLE, SS=1, SCLK=0, MOSI=0, rx=0x00, rxValid=0, busy=0, txReady=0 and all counters to 0.
REQ-033 txReady SHALL rise on the first sysClk edge after reset release.
REQ-034 Reset mid-frame SHALL abort the transfer: SS rises asynchronously and no rxValid is emitted.

Verification
REQ-035 Single byte: tx=0xA5, txLast=1, slave model returns 0x3C, CLK_DIV=4 -> MOSI bits 1,0,1,0,0,1,0,1; 8 SCLK pulses 4 high/4 low; rx=0x3C with one rxValid pulse; SS high 2 cycles after the last falling edge.
REQ-036 Burst: bytes 0x01,0x02,0x03, txLast only on the third, slave echoes the previous byte -> SS low throughout; rx sequence 0x00,0x01,0x02; 24 rising edges total.
REQ-037 Stalled burst: txLast=0, next txValid delayed 100 cycles -> SS stays 0, SCLK stays 0, txReady=1 during the wait; the transfer then resumes correctly.
REQ-038 Frame spacing: two single-byte frames offered back-to-back -> SS high for at least SS_IDLE=4 cycles between them; txReady=0 during GAP.
REQ-039 Reset abort: assert usrReset_n=0 after the 3rd rising edge of a frame -> SS=1 and SCLK=0 without waiting for a clock edge; no rxValid; the next frame after release transfers 0xFF correctly.
REQ-040 Timing sweep: repeat the single-byte case with CLK_DIV=2 and CLK_DIV=255 -> byte time is exactly 32 and 4080 cycles, and data is correct in both.

Source files
------------

// File: rtl/spi_master_byte.sv
// spi_master_byte: SPI mode-0 byte master with SS setup/hold/idle framing and gapless bursts.
module spi_master_byte #(
   parameter int CLK_DIV  = 4,
   parameter int SS_SETUP = 2,
   parameter int SS_IDLE  = 4
) (
   input  logic       sysClk,
   input  logic       usrReset_n,
   input  logic [7:0] tx,
   input  logic       txValid,
   input  logic       txLast,
   output logic       txReady,
   output logic [7:0] rx,
   output logic       rxValid,
   output logic       busy,
   output logic       SCLK,
   output logic       MOSI,
   output logic       SS,
   input  logic       MISO
);
   typedef enum logic [2:0] {IDLE, SETUP, XFER, WAIT, HOLD, GAP} state_t;
   localparam logic [7:0] DIV_LD   = 8'(CLK_DIV - 1);
   localparam logic [7:0] SETUP_LD = 8'(SS_SETUP - 1);
   localparam logic [7:0] IDLE_LD  = 8'(SS_IDLE - 1);
   state_t     r_state, w_next;
   logic [7:0] r_cnt, r_div, r_half, r_txsh, r_rxsh, r_rx;
   logic       r_last, r_sclk, r_mosi, r_ss, r_rxv, r_ready, r_miso_m, r_miso_s;
   logic       w_accept, w_cnt_done, w_tick, w_fall, w_end, w_sample;

   always_comb begin
      w_accept   = txValid && r_ready;
      w_cnt_done = r_cnt == 8'd0;
      w_tick     = r_state == XFER && r_div == 8'd0;
      w_fall     = w_tick && r_sclk;
      w_end      = w_tick && r_half == 8'd15;
      // MISO is taken in the first cycle of each high half, one cycle after the rising edge
      w_sample   = r_state == XFER && r_sclk && r_div == DIV_LD;
      w_next     = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = SETUP;
         SETUP:   if (w_cnt_done) w_next = XFER;
         XFER:    if (w_end) w_next = r_last ? HOLD : WAIT;
         WAIT:    if (w_accept) w_next = XFER;
         HOLD:    if (w_cnt_done) w_next = GAP;
         GAP:     if (w_cnt_done) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge sysClk or negedge usrReset_n) begin
      if (!usrReset_n) r_state <= IDLE;
      else r_state <= w_next;
   end

   always_ff @(posedge sysClk or negedge usrReset_n) begin
      if (!usrReset_n) begin
         r_cnt    <= '0;
         r_div    <= '0;
         r_half   <= '0;
         r_txsh   <= '0;
         r_rxsh   <= '0;
         r_rx     <= '0;
         r_last   <= 1'b0;
         r_sclk   <= 1'b0;
         r_mosi   <= 1'b0;
         r_ss     <= 1'b1;
         r_rxv    <= 1'b0;
         r_ready  <= 1'b0;
         r_miso_m <= 1'b0;
         r_miso_s <= 1'b0;
      end else begin
         r_miso_m <= MISO;
         r_miso_s <= r_miso_m;
         r_ready  <= w_next == IDLE || w_next == WAIT;
         r_ss     <= w_next == IDLE || w_next == GAP;
         r_rxv    <= w_end;
         if (w_next != r_state) r_cnt <= w_next == GAP ? IDLE_LD : SETUP_LD;
         else if (!w_cnt_done) r_cnt <= r_cnt - 8'd1;
         if (w_next == XFER && r_state != XFER) begin
            r_div  <= DIV_LD;
            r_half <= 8'd0;
         end else if (w_tick) begin
            r_div  <= DIV_LD;
            r_half <= r_half + 8'd1;
         end else if (r_div != 8'd0) r_div <= r_div - 8'd1;
         if (w_tick) r_sclk <= ~r_sclk;
         if (w_accept) begin
            r_txsh <= tx;
            r_mosi <= tx[7];
            r_last <= txLast;
         end else if (w_fall && !w_end) begin
            r_txsh <= {r_txsh[6:0], 1'b0};
            r_mosi <= r_txsh[6];
         end
         if (w_sample) r_rxsh <= {r_rxsh[6:0], r_miso_s};
         if (w_end) r_rx <= r_rxsh;
      end
   end

   assign txReady = r_ready;
   assign rx      = r_rx;
   assign rxValid = r_rxv;
   assign busy    = r_state != IDLE;
   assign SCLK    = r_sclk;
   assign MOSI    = r_mosi;
   assign SS      = r_ss;
endmodule

// File: tb/tb_spi_master_byte.sv
// tb_spi_master_byte: directed checks of spi_master_byte at CLK_DIV 4, 2 and 255 against a mode-0 slave model.
module tb_spi_master_byte;
   logic       sysClk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx [3];
   logic [7:0] rx [3];
   logic       txv [3], txl [3], rdy [3], rxv [3], busy [3], sclk [3], mosi [3], ss [3];
   logic       miso [3] = '{1'b0, 1'b0, 1'b0};
   logic       ss_p [3] = '{1'b1, 1'b1, 1'b1};
   logic       sclk_p [3] = '{1'b0, 1'b0, 1'b0};
   logic       echo [3];
   logic [7:0] slave_out [3], cap [3], sh [3], rx_last [3];
   logic [7:0] rx_log [16];
   int         cyc, bc [3], rises [3], rxv_cnt [3], ss_rises [3], rdy_gap [3];
   int         t_ssfall [3], t_ssrise [3], t_rise [3], t_fall [3], t_rxv [3], hi_len [3], gap_len [3];
   int         errors = 0, checks = 0;

   always #5 sysClk = ~sysClk;
   always @(posedge sysClk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      spi_master_byte #(.CLK_DIV(g == 0 ? 4 : g == 1 ? 2 : 255), .SS_SETUP(2), .SS_IDLE(4)) u_dut (
         .sysClk(sysClk), .usrReset_n(rst_n), .tx(tx[g]), .txValid(txv[g]), .txLast(txl[g]),
         .txReady(rdy[g]), .rx(rx[g]), .rxValid(rxv[g]), .busy(busy[g]), .SCLK(sclk[g]),
         .MOSI(mosi[g]), .SS(ss[g]), .MISO(miso[g]));
   end

   // Slave model and event timestamps, sampled mid-cycle; MISO moves after each SCLK fall.
   always @(negedge sysClk) begin
      for (int i = 0; i < 3; i++) begin
         if (ss_p[i] && !ss[i]) begin
            t_ssfall[i] = cyc;
            gap_len[i] = cyc - t_ssrise[i];
            bc[i] = 0;
            sh[i] = slave_out[i];
            miso[i] = sh[i][7];
         end
         if (!ss_p[i] && ss[i]) begin
            t_ssrise[i] = cyc;
            ss_rises[i]++;
         end
         if (!sclk_p[i] && sclk[i]) begin
            cap[i] = {cap[i][6:0], mosi[i]};
            bc[i]++;
            rises[i]++;
            t_rise[i] = cyc;
         end
         if (sclk_p[i] && !sclk[i]) begin
            t_fall[i] = cyc;
            hi_len[i] = cyc - t_rise[i];
            if (bc[i] == 8) begin
               bc[i] = 0;
               sh[i] = echo[i] ? cap[i] : slave_out[i];
            end else sh[i] = {sh[i][6:0], 1'b0};
            miso[i] = sh[i][7];
         end
         if (ss[i] && busy[i] && rdy[i]) rdy_gap[i]++;
         if (rxv[i]) begin
            if (i == 0) rx_log[rxv_cnt[0][3:0]] = rx[0];
            rxv_cnt[i]++;
            t_rxv[i] = cyc;
            rx_last[i] = rx[i];
         end
         ss_p[i] = ss[i];
         sclk_p[i] = sclk[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      errors++;
      $error("FAIL %s: timed out", tag);
   endtask

   task automatic send(input int i, input logic [7:0] b, input logic last);
      int n;
      tx[i] = b;
      txl[i] = last;
      txv[i] = 1'b1;
      for (n = 0; n < 10000 && rdy[i] !== 1'b1; n++) @(negedge sysClk);
      if (n >= 10000) timeout("send_ready");
      @(posedge sysClk);
      #1 txv[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      int n;
      for (n = 0; n < 10000 && busy[i] !== 1'b0; n++) @(negedge sysClk);
      if (n >= 10000) timeout("wait_idle");
   endtask

   task automatic wait_rxv(input int i, input int target);
      int n;
      for (n = 0; n < 10000 && rxv_cnt[i] < target; n++) @(negedge sysClk);
      if (n >= 10000) timeout("wait_rxv");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, x0, s0, g0, bad, n;
      for (int i = 0; i < 3; i++) begin
         tx[i] = 8'h00;
         txv[i] = 1'b0;
         txl[i] = 1'b0;
         slave_out[i] = 8'h00;
         echo[i] = 1'b0;
      end
      repeat (3) @(negedge sysClk);
      chk("rst_ss", ss[0], 1);
      chk("rst_sclk", sclk[0], 0);
      chk("rst_mosi", mosi[0], 0);
      chk("rst_rx", rx[0], 8'h00);
      chk("rst_rxvalid", rxv[0], 0);
      chk("rst_busy", busy[0], 0);
      chk("rst_txready", rdy[0], 0);
      rst_n = 1'b1;
      @(posedge sysClk);
      #1 chk("txready_after_release", rdy[0], 1);
      @(negedge sysClk);

      slave_out[0] = 8'h3C;
      r0 = rises[0];
      x0 = rxv_cnt[0];
      send(0, 8'hA5, 1'b1);
      wait_idle(0);
      chk("single_rx", rx_last[0], 8'h3C);
      chk("single_mosi_bits", cap[0], 8'hA5);
      chk("single_rises", rises[0] - r0, 8);
      chk("single_rxvalid_pulses", rxv_cnt[0] - x0, 1);
      chk("single_sclk_high", hi_len[0], 4);
      chk("single_ss_hold", t_ssrise[0] - t_fall[0], 2);
      chk("single_byte_time", t_rxv[0] - t_ssfall[0] - 2, 64);

      echo[0] = 1'b1;
      slave_out[0] = 8'h00;
      r0 = rises[0];
      x0 = rxv_cnt[0];
      s0 = ss_rises[0];
      send(0, 8'h01, 1'b0);
      send(0, 8'h02, 1'b0);
      send(0, 8'h03, 1'b1);
      wait_rxv(0, x0 + 3);
      chk("burst_ss_low", ss_rises[0] - s0, 0);
      chk("burst_ss_level", ss[0], 0);
      chk("burst_rx0", rx_log[4'(x0)], 8'h00);
      chk("burst_rx1", rx_log[4'(x0 + 1)], 8'h01);
      chk("burst_rx2", rx_log[4'(x0 + 2)], 8'h02);
      chk("burst_rises", rises[0] - r0, 24);
      wait_idle(0);

      slave_out[0] = 8'h5A;
      x0 = rxv_cnt[0];
      send(0, 8'h81, 1'b0);
      wait_rxv(0, x0 + 1);
      bad = 0;
      repeat (100) begin
         @(negedge sysClk);
         if (ss[0] !== 1'b0 || sclk[0] !== 1'b0 || rdy[0] !== 1'b1) bad++;
      end
      chk("stall_lines", bad, 0);
      send(0, 8'h7E, 1'b1);
      wait_idle(0);
      chk("stall_rx0", rx_log[4'(x0)], 8'h5A);
      chk("stall_rx1", rx_log[4'(x0 + 1)], 8'h81);
      chk("stall_mosi_bits", cap[0], 8'h7E);
      chk("stall_rxvalid_pulses", rxv_cnt[0] - x0, 2);

      echo[0] = 1'b0;
      slave_out[0] = 8'h96;
      g0 = rdy_gap[0];
      send(0, 8'h11, 1'b1);
      send(0, 8'h22, 1'b1);
      wait_idle(0);
      chk("gap_ss_high_min", gap_len[0] >= 4, 1);
      chk("gap_txready_low", rdy_gap[0] - g0, 0);
      chk("gap_rx", rx_last[0], 8'h96);
      chk("gap_mosi_bits", cap[0], 8'h22);

      slave_out[0] = 8'h33;
      r0 = rises[0];
      x0 = rxv_cnt[0];
      send(0, 8'h55, 1'b1);
      for (n = 0; n < 1000 && rises[0] - r0 < 3; n++) @(negedge sysClk);
      if (n >= 1000) timeout("abort_third_rise");
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ss", ss[0], 1);
      chk("abort_sclk", sclk[0], 0);
      repeat (20) @(negedge sysClk);
      chk("abort_no_rxvalid", rxv_cnt[0] - x0, 0);
      chk("abort_busy", busy[0], 0);
      rst_n = 1'b1;
      @(negedge sysClk);
      slave_out[0] = 8'hFF;
      send(0, 8'hFF, 1'b1);
      wait_idle(0);
      chk("abort_next_rx", rx_last[0], 8'hFF);
      chk("abort_next_mosi", cap[0], 8'hFF);

      for (int i = 1; i < 3; i++) begin
         slave_out[i] = 8'h3C;
         r0 = rises[i];
         send(i, 8'hA5, 1'b1);
         wait_idle(i);
         chk($sformatf("sweep%0d_rx", i), rx_last[i], 8'h3C);
         chk($sformatf("sweep%0d_mosi_bits", i), cap[i], 8'hA5);
         chk($sformatf("sweep%0d_rises", i), rises[i] - r0, 8);
         chk($sformatf("sweep%0d_byte_time", i), t_rxv[i] - t_ssfall[i] - 2, i == 1 ? 32 : 4080);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
